// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file that zeroes itself with a sweep after reset.
// Define REGFILE_BYPASS_EN to forward a same-cycle in-range write to matching read ports.
module reg_file_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_oob,
    output logic                 busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);
    state_t                 state_q, state_d;
    logic [AW-1:0]          clr_ptr_q, clr_ptr_d;
    logic [NRD*WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [NRD-1:0]         rd_oob_q, rd_oob_d;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic                   wr_ok;
    assign wr_ok   = {1'b0, wr_addr} < DEPTH_W;
    assign busy    = state_q == CLEAR;
    assign rd_data = rd_data_q;
    assign rd_oob  = rd_oob_q;
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = '0;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST) state_d = RUN;
        end
    end
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok, hit;
        assign ra = rd_addr[g*AW +: AW];
        assign ok = {1'b0, ra} < DEPTH_W;
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_en && wr_ok && wr_addr == ra;
`else
        assign hit = 1'b0;
`endif
        assign rd_data_d[g*WIDTH +: WIDTH] = state_q == CLEAR ? '0 :
                                             stall ? rd_data_q[g*WIDTH +: WIDTH] :
                                             !ok ? '0 : hit ? wr_data : mem[ra];
        assign rd_oob_d[g] = state_q == CLEAR ? 1'b0 : stall ? rd_oob_q[g] : !ok;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            rd_data_q <= '0;
            rd_oob_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rd_data_q <= rd_data_d;
            rd_oob_q  <= rd_oob_d;
        end
    end
    // Array has no reset; the sweep clears it and writes under rst are dropped.
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) mem[clr_ptr_q] <= '0;
        else if (!rst && wr_en && wr_ok) mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp with default parameters.
module tb_reg_file_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        string       tag;
        logic [63:0] d;
        logic [1:0]  o;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_oob;
    logic        busy;
    logic [31:0] m [10];
    logic [63:0] exp_d;
    logic [1:0]  exp_o;
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .rd_oob(rd_oob), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sweep(input string tag);
        int n = 0;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hFFFF_FFFF; stall = 1'b1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
            chk({tag, "_rd_zero"}, rd_data, 64'd0);
        end
        wr_en = 1'b0; stall = 1'b0;
        chk({tag, "_len"}, 64'(n), 64'd10);
        foreach (m[i]) m[i] = '0;
        exp_d = '0;
        exp_o = '0;
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic st, input logic [3:0] a0, input logic [3:0] a1, input string tag);
        logic [3:0] a [2];
        exp_t e;
        a[0] = a0; a[1] = a1;
        wr_en = we; wr_addr = wa; wr_data = wd; stall = st; rd_addr = {a1, a0};
        if (!st) begin
            for (int p = 0; p < 2; p++) begin
                exp_o[p] = a[p] >= 4'd10;
                exp_d[p*32 +: 32] = exp_o[p] ? 32'd0 : m[a[p]];
                if (!exp_o[p] && BYP && we && wa == a[p]) exp_d[p*32 +: 32] = wd;
            end
        end
        e.tag = tag; e.d = exp_d; e.o = exp_o;
        sb.push_back(e);
        @(posedge clk); #1;
        if (we && wa < 4'd10) m[wa] = wd;
        e = sb.pop_front();
        chk({e.tag, "_data"}, rd_data, e.d);
        chk({e.tag, "_oob"}, 64'(rd_oob), 64'(e.o));
        wr_en = 1'b0; stall = 1'b0;
    endtask

    initial begin
        foreach (m[i]) m[i] = '0;
        exp_d = '0;
        exp_o = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rd", rd_data, 64'd0);
        chk("rst_oob", 64'(rd_oob), 64'd0);
        @(negedge clk); rst = 1'b0;
        sweep("boot");
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'(i), 4'(9 - i), "clr_all");
        step(1, 3, 32'hDEADBEEF, 0, 0, 1, "wr3");
        step(0, 0, 0, 0, 3, 3, "rd3");
        chk("rd3_const", rd_data, {2{32'hDEADBEEF}});
        step(0, 0, 0, 0, 12, 3, "oob12");
        chk("oob12_const", 64'(rd_oob), 64'd1);
        step(1, 12, 32'h5555_5555, 0, 15, 10, "wr12");
        for (int i = 0; i < 10; i += 2) step(0, 0, 0, 0, 4'(i), 4'(i + 1), "after_wr12");
        step(1, 5, 32'h1111, 0, 0, 0, "wr5a");
        step(0, 0, 0, 0, 5, 3, "rd5a");
        for (int i = 0; i < 3; i++) begin
            step(1, 5, 32'h1234, 1, 12, 7, "stall");
            chk("stall_hold", rd_data, {32'hDEADBEEF, 32'h1111});
        end
        step(0, 0, 0, 0, 5, 12, "rd5b");
        chk("rd5b_const", rd_data[31:0], 64'h1234);
        step(1, 7, 32'h77, 0, 0, 0, "wr7");
        step(1, 7, 32'hA5, 0, 7, 7, "byp7");
        chk("byp7_const", rd_data, BYP ? {2{32'hA5}} : {2{32'h77}});
        step(0, 0, 0, 0, 7, 9, "rd7");
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hBAD;
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd1);
        chk("async_rd", rd_data, 64'd0);
        chk("async_oob", 64'(rd_oob), 64'd0);
        @(negedge clk); @(negedge clk);
        wr_en = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort_busy", 64'(busy), 64'd1);
        @(negedge clk); rst = 1'b0;
        sweep("abort");
        for (int i = 0; i < 10; i += 2) step(0, 0, 0, 0, 4'(i), 4'(i + 1), "post_abort");
        step(0, 0, 0, 0, 13, 14, "oob_both");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
